// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per clock,
// LSB first, through one full-subtractor cell and a borrow flip-flop.
// A start/ready/done handshake accepts operands and returns a registered
// result together with borrow-out and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Result bits collected so far. The final bit never needs storing because it
  // is merged straight into diff on the last shift, so WIDTH-1 bits suffice.
  logic [WIDTH-2:0] d_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] d_next;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
  assign bo_bit = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign d_next = {d_bit, d_sr};

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  // Handshake FSM, operand shifting and result registers.
  // NOTE: every register here is updated with <= so all right-hand sides see
  // the pre-edge values; blocking writes would leak new state into the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            d_sr  <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next[WIDTH-1:1];
          br   <= bo_bit;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= d_next;
            bout  <= bo_bit;
            zero  <= (d_next == '0);
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
